pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Fetch/execute controller that drives the 8-bit program counter's Load, CountEn and A inputs. It fetches a 16-bit instruction over a req/ack handshake addressed by the current PC value. It classifies the opcode and issues exactly one PC update per instruction: increment, jump, conditional branch, call or return. It holds a 4-entry return-address stack and sits between the instruction memory interface and the program counter.

Parameters:
STACK_DEPTH, 4, number of return-address stack entries (power of two, 2..16)
AW, 8, PC/address width; matches the program counter width

Ports:
Clk  in  1  clock, all state updates on rising edge
nReset  in  1  asynchronous, active-low reset
Start  in  1  level; leaves IDLE when high
PcValue  in  AW  current program counter output (Y)
PcLoad  out  1  drives program counter Load
PcCountEn  out  1  drives program counter CountEn
PcLoadVal  out  AW  drives program counter A
FetchReq  out  1  instruction fetch request, address = PcValue
FetchAck  in  1  memory ack; Instr valid in the same cycle
Instr  in  16  [15:12] opcode, [7:0] target
CondFlag  in  1  branch condition, sampled in EXEC
Busy  out  1  high in any state other than IDLE/HALT
Halted  out  1  high in HALT
StackErr  out  1  sticky; stack overflow or underflow occurred

Behaviour:
- Reset (async, nReset=0): state=IDLE, stack pointer=0, all stack entries=0, latched instr=0. All outputs are 0, including PcLoadVal=0 and StackErr=0. Assertion mid-fetch drops FetchReq immediately. A late FetchAck is ignored.
- The program counter samples PcLoad/PcCountEn/PcLoadVal on the same Clk edge that ends EXEC. PcValue is updated by the next FETCH.
- States: IDLE, FETCH, EXEC, HALT.
- IDLE: outputs low. If Start=1, go to FETCH next cycle.
- FETCH: FetchReq=1. It is held high until a cycle with FetchAck=1; no timeout. On that cycle, latch Instr and go to EXEC. FetchAck while not in FETCH is ignored.
- EXEC lasts one cycle, decodes the latched opcode, and asserts at most one of PcLoad/PcCountEn:
  - 0x0 NOP: PcCountEn=1.
  - 0x1 JMP: PcLoad=1, PcLoadVal=target.
  - 0x2 BRZ: if CondFlag=1 then PcLoad=1, PcLoadVal=target; else PcCountEn=1.
  - 0x3 CALL: push (PcValue+1) mod 2^AW, then PcLoad=1, PcLoadVal=target.
  - 0x4 RET: pop top, then PcLoad=1, PcLoadVal=popped value.
  - 0xF HALT: no PC update; go to HALT.
  - All other opcodes: treated as NOP.
  - Next state is FETCH, except for HALT or an error.
- Stack is LIFO with pointer 0..STACK_DEPTH.
  - CALL with pointer=STACK_DEPTH (full) is overflow: no push, no PC update, StackErr=1, go to HALT.
  - RET with pointer=0 (empty) is underflow: same handling.
  - CALL to the full-minus-one level succeeds normally.
- HALT: Halted=1, Busy=0, all PC controls 0. Start is ignored. Exit only via nReset.
- PcLoadVal is 0 whenever PcLoad=0.
- PC wrap: NOP at PcValue=0xFF counts to 0x00 (program counter behaviour). CALL at 0xFF pushes 0x00.
- Start is sampled only in IDLE. Dropping Start mid-program has no effect.

Test Plan:
- Reset then Start=1. Memory acks after 2 wait cycles with NOP at 0x00. Expect FetchReq high for 3 cycles, then one EXEC cycle with PcCountEn=1, then fetch at 0x01.
- JMP 0x40 at 0x05: PcLoad=1, PcLoadVal=0x40 for one cycle. BRZ 0x10 with CondFlag=0 gives PcCountEn. With CondFlag=1 it gives PcLoad, PcLoadVal=0x10.
- CALL 0x80 at 0x20, then RET at 0x80. Expect push 0x21, load 0x80, then load 0x21 and pointer back to 0.
- Five nested CALLs with STACK_DEPTH=4: the first four load their targets. The fifth gives StackErr=1 and Halted=1 with no PcLoad. Start toggling is then ignored.
- RET on an empty stack: StackErr=1 and HALT. nReset pulse clears StackErr and Halted and returns to IDLE.
- nReset asserted while FetchReq=1 and before ack: FetchReq drops asynchronously and all outputs go to 0. A stale FetchAck after release is ignored in IDLE.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch/execute controller for an 8-bit program counter: fetches one 16-bit
// instruction per PC value, then issues a single PC update with a small return-address stack.
module pc_sequencer #(
  parameter int STACK_DEPTH = 4,
  parameter int AW          = 8,
  localparam int SPW        = $clog2(STACK_DEPTH + 1)
) (
  input  logic          Clk,
  input  logic          nReset,
  input  logic          Start,
  input  logic [AW-1:0] PcValue,
  output logic          PcLoad,
  output logic          PcCountEn,
  output logic [AW-1:0] PcLoadVal,
  output logic          FetchReq,
  input  logic          FetchAck,
  input  logic [15:0]   Instr,
  input  logic          CondFlag,
  output logic          Busy,
  output logic          Halted,
  output logic          StackErr,
  output logic [1:0]    DbgState,
  output logic [SPW-1:0] DbgSp,
  output logic [15:0]   DbgInstr
);

  // Handshake: FetchReq stays high through FETCH until the first cycle with
  // FetchAck=1; Instr is valid in that same cycle and is latched on its edge.
  // FetchAck outside FETCH is ignored.

  localparam int IW = $clog2(STACK_DEPTH);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_JMP  = 4'h1;
  localparam logic [3:0] OP_BRZ  = 4'h2;
  localparam logic [3:0] OP_CALL = 4'h3;
  localparam logic [3:0] OP_RET  = 4'h4;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t          state;
  logic [SPW-1:0]  sp;
  logic [15:0]     instr_q;
  logic [AW-1:0]   stack [STACK_DEPTH];

  logic [3:0]      op;
  logic [AW-1:0]   tgt;
  logic            stack_full;
  logic            stack_empty;
  logic [IW-1:0]   top_idx;
  logic [IW-1:0]   push_idx;

  logic            do_load;
  logic            do_count;
  logic [AW-1:0]   load_val;
  logic            do_push;
  logic            do_pop;
  logic            exec_err;
  logic            exec_halt;

  assign op          = instr_q[15:12];
  assign tgt         = AW'(instr_q[7:0]);
  assign stack_full  = (sp == SPW'(STACK_DEPTH));
  assign stack_empty = (sp == '0);
  // Power-of-two depth lets the pointer wrap harmlessly into the index range.
  assign top_idx     = IW'(sp - SPW'(1));
  assign push_idx    = IW'(sp);

  // The PC controls decode combinationally in EXEC because CondFlag and the
  // stack pointer are only meaningful in that cycle; the counter samples them
  // on the edge that ends EXEC.
  always_comb begin
    do_load   = 1'b0;
    do_count  = 1'b0;
    load_val  = '0;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    exec_err  = 1'b0;
    exec_halt = 1'b0;
    if (state == S_EXEC) begin
      case (op)
        OP_NOP: do_count = 1'b1;
        OP_JMP: begin
          do_load  = 1'b1;
          load_val = tgt;
        end
        OP_BRZ: begin
          if (CondFlag) begin
            do_load  = 1'b1;
            load_val = tgt;
          end else begin
            do_count = 1'b1;
          end
        end
        OP_CALL: begin
          if (stack_full) begin
            exec_err = 1'b1;
          end else begin
            do_push  = 1'b1;
            do_load  = 1'b1;
            load_val = tgt;
          end
        end
        OP_RET: begin
          if (stack_empty) begin
            exec_err = 1'b1;
          end else begin
            do_pop   = 1'b1;
            do_load  = 1'b1;
            load_val = stack[top_idx];
          end
        end
        OP_HALT: exec_halt = 1'b1;
        default: do_count = 1'b1;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state    <= S_IDLE;
      sp       <= '0;
      instr_q  <= '0;
      StackErr <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (Start) state <= S_FETCH;
        end
        S_FETCH: begin
          if (FetchAck) begin
            instr_q <= Instr;
            state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (do_push) begin
            stack[push_idx] <= PcValue + AW'(1);
            sp              <= sp + SPW'(1);
          end
          if (do_pop) sp <= sp - SPW'(1);
          if (exec_err) StackErr <= 1'b1;
          state <= (exec_err || exec_halt) ? S_HALT : S_FETCH;
        end
        S_HALT: state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Status outputs are plain decodes of the state register, so reset clears
  // them asynchronously (FetchReq drops the moment nReset falls).
  assign FetchReq  = (state == S_FETCH);
  assign Busy      = (state == S_FETCH) || (state == S_EXEC);
  assign Halted    = (state == S_HALT);
  assign PcLoad    = do_load;
  assign PcCountEn = do_count;
  assign PcLoadVal = load_val;
  assign DbgState  = state;
  assign DbgSp     = sp;
  assign DbgInstr  = instr_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: an instruction-level interpreter predicts every PC
// update and halt; a monitor compares them as the DUT presents them.
module tb_pc_sequencer;

  localparam int AW = 8;
  localparam int DEPTH = 4;
  localparam int W = 10;
  localparam int MAX_CYC = 3000;
  localparam logic [1:0] K_COUNT = 2'd1;
  localparam logic [1:0] K_LOAD  = 2'd2;
  localparam logic [1:0] K_HALT  = 2'd3;

  logic          Clk = 1'b0;
  logic          nReset = 1'b0;
  logic          Start = 1'b0;
  logic [AW-1:0] PcValue;
  logic          PcLoad, PcCountEn, FetchReq, Busy, Halted, StackErr;
  logic [AW-1:0] PcLoadVal;
  logic          FetchAck;
  logic [15:0]   Instr;
  logic          CondFlag;
  logic [1:0]    DbgState;
  logic [2:0]    DbgSp;
  logic [15:0]   DbgInstr;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];
  logic [15:0]  mem [256];
  logic         cond_seq [256];
  bit           model_halts;
  int           model_final_sp;
  bit           resp_en = 1'b1;
  logic         stale_ack = 1'b0;
  int           fix_wait = -1;
  bit           halted_seen = 1'b0;
  logic [W-1:0] obs;

  pc_sequencer #(.STACK_DEPTH(DEPTH), .AW(AW)) dut (
    .Clk(Clk), .nReset(nReset), .Start(Start), .PcValue(PcValue),
    .PcLoad(PcLoad), .PcCountEn(PcCountEn), .PcLoadVal(PcLoadVal),
    .FetchReq(FetchReq), .FetchAck(FetchAck), .Instr(Instr), .CondFlag(CondFlag),
    .Busy(Busy), .Halted(Halted), .StackErr(StackErr),
    .DbgState(DbgState), .DbgSp(DbgSp), .DbgInstr(DbgInstr)
  );

  // ---------------- clock / program counter environment ----------------
  always #5 Clk = ~Clk;

  always @(posedge Clk or negedge nReset) begin
    if (!nReset) PcValue <= '0;
    else if (PcLoad) PcValue <= PcLoadVal;
    else if (PcCountEn) PcValue <= PcValue + 8'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [7:0] tgt);
    return {op, 4'h0, tgt};
  endfunction

  function automatic logic [3:0] rand_op();
    int r;
    r = $urandom_range(0, 99);
    if (r < 25) return 4'h0;
    if (r < 35) return 4'h1;
    if (r < 55) return 4'h2;
    if (r < 75) return 4'h3;
    if (r < 88) return 4'h4;
    if (r < 93) return 4'h7;
    return 4'hF;
  endfunction

  // ---------------- instruction memory responder ----------------
  initial begin
    int wcnt, kidx, wtarget;
    FetchAck = 1'b0; Instr = '0; CondFlag = 1'b0;
    wcnt = 0; kidx = 0; wtarget = 0;
    forever begin
      @(negedge Clk);
      if (!nReset) begin
        FetchAck = 1'b0; wcnt = 0; kidx = 0;
        wtarget = (fix_wait >= 0) ? fix_wait : $urandom_range(0, 2);
      end else if (!resp_en) begin
        FetchAck = stale_ack;
      end else if (FetchAck) begin
        FetchAck = 1'b0; wcnt = 0;
      end else if (FetchReq) begin
        if (wcnt >= wtarget) begin
          FetchAck = 1'b1;
          Instr    = mem[PcValue];
          CondFlag = cond_seq[kidx[7:0]];
          kidx++;
          wtarget  = (fix_wait >= 0) ? fix_wait : $urandom_range(0, 2);
        end else begin
          wcnt++;
        end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge Clk) begin
    if (!nReset) begin
      halted_seen = 1'b0;
    end else begin
      if (PcLoad || PcCountEn || (Halted && !halted_seen)) begin
        obs = Halted ? {K_HALT, 7'd0, StackErr} :
              PcLoad ? {K_LOAD, PcLoadVal} : {K_COUNT, 8'd0};
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_update: got %0h, expected none", obs);
        end else begin
          check("pc_update", obs, exp_q.pop_front());
        end
      end
      check("load_count_exclusive", PcLoad & PcCountEn, 0);
      if (!PcLoad) check("loadval_zero", PcLoadVal, 0);
      halted_seen = Halted;
    end
  end

  // ---------------- reference interpreter ----------------
  task automatic model_run(input int max_steps);
    logic [7:0]  pc;
    logic [7:0]  stk[$];
    logic [15:0] ins;
    logic [7:0]  tgt;
    pc = 8'h00;
    model_halts = 1'b0;
    for (int k = 0; k < max_steps; k++) begin
      ins = mem[pc];
      tgt = ins[7:0];
      case (ins[15:12])
        4'h1: begin exp_q.push_back({K_LOAD, tgt}); pc = tgt; end
        4'h2: begin
          if (cond_seq[k]) begin exp_q.push_back({K_LOAD, tgt}); pc = tgt; end
          else begin exp_q.push_back({K_COUNT, 8'd0}); pc = pc + 8'd1; end
        end
        4'h3: begin
          if (stk.size() == DEPTH) begin
            exp_q.push_back({K_HALT, 8'd1}); model_halts = 1'b1;
          end else begin
            stk.push_back(pc + 8'd1);
            exp_q.push_back({K_LOAD, tgt}); pc = tgt;
          end
        end
        4'h4: begin
          if (stk.size() == 0) begin
            exp_q.push_back({K_HALT, 8'd1}); model_halts = 1'b1;
          end else begin
            pc = stk.pop_back();
            exp_q.push_back({K_LOAD, pc});
          end
        end
        4'hF: begin exp_q.push_back({K_HALT, 8'd0}); model_halts = 1'b1; end
        default: begin exp_q.push_back({K_COUNT, 8'd0}); pc = pc + 8'd1; end
      endcase
      if (model_halts) break;
    end
    model_final_sp = stk.size();
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_reset(input string name);
    nReset = 1'b0;
    repeat (2) @(posedge Clk);
    #2;
    check({name, "_reset_outputs"},
          {PcLoad, PcCountEn, PcLoadVal, FetchReq, Busy, Halted, StackErr, DbgState, DbgSp}, 0);
    exp_q.delete();
  endtask

  task automatic fill_halt();
    for (int a = 0; a < 256; a++) begin
      mem[a] = 16'hF000;
      cond_seq[a] = 1'b0;
    end
  endtask

  task automatic run_program(input string name, input int max_steps, input bit toggle_start,
                             input bit measure);
    int cyc, n;
    Start = 1'b1;
    apply_reset(name);
    model_run(max_steps);
    nReset = 1'b1;
    if (measure) begin
      n = 0;
      @(posedge Clk); #2;
      while (FetchReq && n < 10) begin
        n++;
        @(posedge Clk); #2;
      end
      check({name, "_fetch_width"}, n, 3);
    end
    cyc = 0;
    while (!(model_halts ? halted_seen : (exp_q.size() == 0)) && cyc < MAX_CYC) begin
      @(posedge Clk); #2;
      cyc++;
      if (toggle_start && cyc > 3) Start = 1'($urandom_range(0, 1));
    end
    check({name, "_timeout"}, cyc >= MAX_CYC, 0);
    check({name, "_queue_drained"}, exp_q.size(), 0);
    if (model_halts) begin
      check({name, "_halt_status"}, {Halted, Busy, FetchReq}, 3'b100);
      check({name, "_final_sp"}, DbgSp, model_final_sp);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    // basic flow: NOPs, JMP, BRZ both ways, CALL/RET pair, HALT
    fill_halt();
    for (int a = 0; a < 5; a++) mem[a] = enc(4'h0, 8'h00);
    mem[8'h05] = enc(4'h1, 8'h40);
    mem[8'h40] = enc(4'h2, 8'h10);
    mem[8'h41] = enc(4'h2, 8'h10);
    mem[8'h10] = enc(4'h1, 8'h20);
    mem[8'h20] = enc(4'h3, 8'h80);
    mem[8'h80] = enc(4'h4, 8'h00);
    cond_seq[6] = 1'b0;
    cond_seq[7] = 1'b1;
    fix_wait = 2;
    run_program("basic", 40, 1'b0, 1'b1);
    fix_wait = -1;

    // nested CALLs: the fifth overflows the stack
    fill_halt();
    mem[8'h00] = enc(4'h3, 8'h10);
    mem[8'h10] = enc(4'h3, 8'h20);
    mem[8'h20] = enc(4'h3, 8'h30);
    mem[8'h30] = enc(4'h3, 8'h40);
    mem[8'h40] = enc(4'h3, 8'h50);
    run_program("overflow", 40, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge Clk); #2;
      Start = ~Start;
    end
    check("overflow_halt_holds", {Halted, Busy, StackErr, DbgState}, 5'b10111);

    // RET on an empty stack, then a reset pulse clears the error
    fill_halt();
    mem[8'h00] = enc(4'h4, 8'h00);
    run_program("underflow", 40, 1'b0, 1'b0);
    check("underflow_err", StackErr, 1);
    apply_reset("after_underflow");

    // wrap-around: CALL at 0xFF pushes 0x00, NOP at 0xFF counts to 0x00
    fill_halt();
    mem[8'h00] = enc(4'h1, 8'hFF);
    mem[8'hFF] = enc(4'h3, 8'h30);
    mem[8'h30] = enc(4'h4, 8'h00);
    run_program("call_wrap", 9, 1'b1, 1'b0);
    fill_halt();
    mem[8'h00] = enc(4'h1, 8'hFF);
    mem[8'hFF] = enc(4'h0, 8'h00);
    run_program("nop_wrap", 7, 1'b1, 1'b0);

    // reset in the middle of a fetch, then a stale ack while idle
    resp_en = 1'b0;
    stale_ack = 1'b0;
    Start = 1'b1;
    apply_reset("midfetch_pre");
    nReset = 1'b1;
    repeat (2) @(posedge Clk);
    #2;
    check("midfetch_req_high", FetchReq, 1);
    #1 nReset = 1'b0;
    #1;
    check("midfetch_async_drop",
          {PcLoad, PcCountEn, PcLoadVal, FetchReq, Busy, Halted, StackErr}, 0);
    Start = 1'b0;
    @(posedge Clk); #2;
    nReset = 1'b1;
    stale_ack = 1'b1;
    repeat (3) @(posedge Clk);
    #2;
    check("stale_ack_ignored", {Busy, FetchReq, DbgState}, 0);
    stale_ack = 1'b0;
    @(posedge Clk); #2;
    resp_en = 1'b1;

    // randomized programs
    for (int r = 0; r < 12; r++) begin
      for (int a = 0; a < 256; a++) begin
        mem[a] = {rand_op(), 4'($urandom), 8'($urandom)};
        cond_seq[a] = 1'($urandom_range(0, 1));
      end
      run_program("random", 40, 1'b1, 1'b0);
    end

    nReset = 1'b0;
    @(posedge Clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
